// File: rtl/fft_result_streamer.sv
// fft_result_streamer: streams 16 FFT results from memory over valid/ready with optional bit-reversal and scaling
module fft_result_streamer #(
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  scale_shift,
  output logic        busy,
  output logic        mem_lock,
  output logic        done,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [31:0] out_data,
  output logic [3:0]  out_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic [3:0] index_q, index_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d, load;
  logic signed [15:0] re_s, im_s;
  always_comb begin
    re_s = $signed(rd_data[31:16]) >>> shift_q;
    im_s = $signed(rd_data[15:0]) >>> shift_q;
    load = state_q == STREAM && !cnt_q[4] && (!valid_q || out_ready);
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    data_d = data_q;
    index_d = index_q;
    valid_d = valid_q;
    last_d = last_q;
    done_d = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = STREAM;
      cnt_d = 5'd0;
      shift_d = scale_shift;
    end
    if (load) begin
      data_d = {re_s, im_s};
      index_d = cnt_q[3:0];
      last_d = cnt_q[3:0] == 4'd15;
      valid_d = 1'b1;
      cnt_d = cnt_q + 5'd1;
    end else if (state_q == STREAM && cnt_q[4] && valid_q && out_ready) begin
      valid_d = 1'b0;
      last_d = 1'b0;
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == STREAM;
  assign mem_lock = busy;
  assign done = done_q;
  assign rd_addr = state_q != STREAM ? 4'd0 :
                   BIT_REVERSE ? {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]} : cnt_q[3:0];
  assign out_data = data_q;
  assign out_index = index_q;
  assign out_valid = valid_q;
  assign out_last = last_q;
endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer: bit-reversed and linear instances checked against a floor-division reference model
module tb_fft_result_streamer;
  logic clk = 1'b0, rst, start, out_ready;
  logic [1:0] scale_shift;
  logic [31:0] mem [16];
  logic [3:0] addr_b, addr_l, idx_b, idx_l;
  logic [31:0] data_b, data_l, odata_b, odata_l;
  logic busy_b, busy_l, lock_b, lock_l, done_b, done_l, valid_b, valid_l, last_b, last_l;
  logic [31:0] cap_b [16], cap_l [16];
  int n_cmp = 0, n_bad = 0;

  assign data_b = mem[addr_b];
  assign data_l = mem[addr_l];
  always #5 clk = ~clk;

  fft_result_streamer #(.BIT_REVERSE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .scale_shift(scale_shift), .busy(busy_b),
    .mem_lock(lock_b), .done(done_b), .rd_addr(addr_b), .rd_data(data_b),
    .out_data(odata_b), .out_index(idx_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_last(last_b));
  fft_result_streamer #(.BIT_REVERSE(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .scale_shift(scale_shift), .busy(busy_l),
    .mem_lock(lock_l), .done(done_l), .rd_addr(addr_l), .rd_data(data_l),
    .out_data(odata_l), .out_index(idx_l), .out_valid(valid_l), .out_ready(out_ready),
    .out_last(last_l));

  typedef struct {int k; logic [31:0] eb; logic [31:0] el;} order_t;
  typedef struct {logic [31:0] w; logic [1:0] sh; logic [31:0] e;} scale_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] floor_shift(input logic [15:0] v, input int s);
    int x, d, q;
    x = int'($signed(v));
    d = 1 << s;
    q = x >= 0 ? x / d : -((-x + d - 1) / d);
    return q[15:0];
  endfunction

  function automatic logic [31:0] model(input logic [31:0] w, input int s);
    return {floor_shift(w[31:16], s), floor_shift(w[15:0], s)};
  endfunction

  function automatic int rev4(input int k);
    int r = 0;
    for (int i = 0; i < 4; i++) if (((k >> i) & 1) != 0) r += 1 << (3 - i);
    return r;
  endfunction

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ctl_b"}, {busy_b, lock_b, done_b, valid_b, last_b, idx_b, addr_b}, 0);
    chk({nm, "_ctl_l"}, {busy_l, lock_l, done_l, valid_l, last_l, idx_l, addr_l}, 0);
    chk({nm, "_data_b"}, odata_b, 0);
    chk({nm, "_data_l"}, odata_l, 0);
  endtask

  task automatic run_frame(input logic [1:0] sh, input bit rnd, input bit restart);
    logic [31:0] eb [16], el [16];
    logic [31:0] hold_b, hold_l;
    int beats = 0, stalls = 0;
    bit fin = 0, stalled = 0;
    for (int k = 0; k < 16; k++) begin
      eb[k] = model(mem[rev4(k)], int'(sh));
      el[k] = model(mem[k], int'(sh));
    end
    start = 1'b1;
    scale_shift = sh;
    @(posedge clk); #1;
    start = 1'b0;
    scale_shift = 2'($urandom);
    chk("busy_after_start", {busy_b, lock_b, busy_l, lock_l}, 4'hF);
    for (int c = 0; c < 400 && !fin; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = restart && c == 3;
      @(negedge clk);
      if (done_b) begin
        fin = 1;
        chk("done_time", c, 17 + stalls);
        chk("beat_count", beats, 16);
        chk("done_l", done_l, 1);
        chk("idle_after_done", {busy_b, lock_b, valid_b, busy_l, valid_l}, 0);
      end else if (valid_b) begin
        if (beats > 15) chk("extra_beat", beats, 15);
        else begin
          if (stalled) begin
            chk("stall_hold_b", odata_b, hold_b);
            chk("stall_hold_l", odata_l, hold_l);
          end
          chk("data_b", odata_b, eb[beats]);
          chk("data_l", odata_l, el[beats]);
          chk("index", {idx_b, idx_l}, {beats[3:0], beats[3:0]});
          chk("last", {last_b, last_l, valid_l}, {beats == 15, beats == 15, 1'b1});
          cap_b[beats] = odata_b;
          cap_l[beats] = odata_l;
          hold_b = odata_b;
          hold_l = odata_l;
          stalled = !out_ready;
          if (out_ready) beats++; else stalls++;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (!fin) chk("done_timeout", 0, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", {done_b, done_l}, 0);
    @(posedge clk); #1;
  endtask

  order_t ov [5];
  scale_t sv [4];

  initial begin
    ov[0] = '{0, 32'h0000_0000, 32'h0000_0000};
    ov[1] = '{1, 32'h0008_0008, 32'h0001_0001};
    ov[2] = '{2, 32'h0004_0004, 32'h0002_0002};
    ov[3] = '{3, 32'h000C_000C, 32'h0003_0003};
    ov[4] = '{15, 32'h000F_000F, 32'h000F_000F};
    sv[0] = '{32'h8000_7FFF, 2'd2, 32'hE000_1FFF};
    sv[1] = '{32'h8000_7FFF, 2'd0, 32'h8000_7FFF};
    sv[2] = '{32'hFFFF_0001, 2'd1, 32'hFFFF_0000};
    sv[3] = '{32'h8001_7FFF, 2'd3, 32'hF000_0FFF};
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    scale_shift = 2'd0;
    for (int a = 0; a < 16; a++) mem[a] = {12'h0, 4'(a), 12'h0, 4'(a)};
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(2'd0, 1'b0, 1'b0);
    foreach (ov[i]) begin
      chk($sformatf("order_br_k%0d", ov[i].k), cap_b[ov[i].k], ov[i].eb);
      chk($sformatf("order_lin_k%0d", ov[i].k), cap_l[ov[i].k], ov[i].el);
    end
    foreach (sv[i]) begin
      mem[0] = sv[i].w;
      run_frame(sv[i].sh, 1'b0, 1'b0);
      chk($sformatf("scale_br_%0d", i), cap_b[0], sv[i].e);
      chk($sformatf("scale_lin_%0d", i), cap_l[0], sv[i].e);
    end
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < 16; a++) mem[a] = $urandom;
      run_frame(2'($urandom), 1'b1, 1'b0);
    end
    run_frame(2'd1, 1'b1, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("pre_reset_beats", {valid_b, idx_b}, {1'b1, 4'd5});
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("no_done_after_reset", {done_b, done_l, busy_b}, 0);
    run_frame(2'd0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
